// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - Round-robin write-port arbiter and clear sequencer for the register file
module regfile_write_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  CoreValid,
    input  logic [ADDR_WIDTH-1:0] CoreAddress,
    input  logic [DATA_WIDTH-1:0] CoreData,
    output logic                  CoreReady,
    input  logic                  DbgValid,
    input  logic [ADDR_WIDTH-1:0] DbgAddress,
    input  logic [DATA_WIDTH-1:0] DbgData,
    output logic                  DbgReady,
    input  logic                  ClearRequest,
    output logic                  ClearBusy,
    output logic [ADDR_WIDTH-1:0] WriteRegAddress,
    output logic [DATA_WIDTH-1:0] DataOfWrite,
    output logic                  WriteControl,
    output logic                  LastGrant
);
    typedef enum logic {RUN = 1'b0, CLEAR = 1'b1} state_t;

    localparam state_t                RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;

    state_t                state;
    state_t                nextState;
    logic [ADDR_WIDTH-1:0] counter;
    logic                  clearTail;
    logic                  grantCore;
    logic                  grantDbg;

    // Clear has priority over both requesters; ties go to whoever did not win last.
    always_comb begin
        nextState = state;
        grantCore = 1'b0;
        grantDbg  = 1'b0;
        case (state)
            RUN: begin
                if (ClearRequest) begin
                    nextState = CLEAR;
                end else if (CoreValid && DbgValid) begin
                    grantCore = LastGrant;
                    grantDbg  = !LastGrant;
                end else begin
                    grantCore = CoreValid;
                    grantDbg  = DbgValid;
                end
            end
            CLEAR: begin
                if (counter == LAST_ADDR) begin
                    nextState = RUN;
                end
            end
        endcase
    end

    assign CoreReady = grantCore;
    assign DbgReady  = grantDbg;
    // Busy also covers the cycle in which the final clear write is on the port.
    assign ClearBusy = (state == CLEAR) || clearTail;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= RESET_STATE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            counter         <= FIRST_ADDR;
            clearTail       <= 1'b0;
            WriteControl    <= 1'b0;
            WriteRegAddress <= '0;
            DataOfWrite     <= '0;
            LastGrant       <= 1'b1;
        end else begin
            clearTail <= (state == CLEAR);
            if (state == CLEAR) begin
                WriteRegAddress <= counter;
                DataOfWrite     <= '0;
                WriteControl    <= 1'b1;
                counter         <= (counter == LAST_ADDR) ? FIRST_ADDR : counter + FIRST_ADDR;
            end else if (ClearRequest) begin
                WriteControl <= 1'b0;
                counter      <= FIRST_ADDR;
            end else if (grantCore) begin
                // r0 is hardwired to zero, so its writes are accepted but never enabled.
                WriteRegAddress <= CoreAddress;
                DataOfWrite     <= CoreData;
                WriteControl    <= (CoreAddress != '0);
                LastGrant       <= 1'b0;
            end else if (grantDbg) begin
                WriteRegAddress <= DbgAddress;
                DataOfWrite     <= DbgData;
                WriteControl    <= (DbgAddress != '0);
                LastGrant       <= 1'b1;
            end else begin
                WriteControl <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - Scoreboard bench for the register file write arbiter
module tb_regfile_write_arbiter;
    logic        Clock;
    logic        Reset;
    logic        CoreValid;
    logic [4:0]  CoreAddress;
    logic [31:0] CoreData;
    logic        CoreReady;
    logic        DbgValid;
    logic [4:0]  DbgAddress;
    logic [31:0] DbgData;
    logic        DbgReady;
    logic        ClearRequest;
    logic        ClearBusy;
    logic [4:0]  WriteRegAddress;
    logic [31:0] DataOfWrite;
    logic        WriteControl;
    logic        LastGrant;

    regfile_write_arbiter dut (
        .Clock(Clock), .Reset(Reset),
        .CoreValid(CoreValid), .CoreAddress(CoreAddress), .CoreData(CoreData), .CoreReady(CoreReady),
        .DbgValid(DbgValid), .DbgAddress(DbgAddress), .DbgData(DbgData), .DbgReady(DbgReady),
        .ClearRequest(ClearRequest), .ClearBusy(ClearBusy),
        .WriteRegAddress(WriteRegAddress), .DataOfWrite(DataOfWrite),
        .WriteControl(WriteControl), .LastGrant(LastGrant)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        int          cyc;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         expQ[$];
    logic [31:0] rf[32];
    logic [31:0] expRf[32];
    int          checks;
    int          failures;
    int          cycle;
    int          clearLeft;
    bit          lastG;
    bit          clearVis;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endfunction

    function automatic void modelReset();
        expQ.delete();
        clearLeft = 31;
        lastG     = 1'b1;
        clearVis  = 1'b0;
    endfunction

    function automatic void push(logic [4:0] a, logic [31:0] d);
        expQ.push_back('{cycle, a, d});
        expRf[a] = d;
    endfunction

    function automatic void predict(output bit gc, output bit gd);
        gc = 1'b0;
        gd = 1'b0;
        if (clearLeft == 0 && !ClearRequest) begin
            if (CoreValid && DbgValid) begin
                if (lastG) gc = 1'b1;
                else       gd = 1'b1;
            end else if (CoreValid) begin
                gc = 1'b1;
            end else if (DbgValid) begin
                gd = 1'b1;
            end
        end
    endfunction

    function automatic void modelEdge(bit gc, bit gd);
        if (clearLeft > 0) begin
            push(5'(32 - clearLeft), 32'h0);
            clearLeft--;
            clearVis = 1'b1;
        end else begin
            clearVis = 1'b0;
            if (ClearRequest) begin
                clearLeft = 31;
            end else if (gc) begin
                lastG = 1'b0;
                if (CoreAddress != 5'd0) push(CoreAddress, CoreData);
            end else if (gd) begin
                lastG = 1'b1;
                if (DbgAddress != 5'd0) push(DbgAddress, DbgData);
            end
        end
    endfunction

    // Inputs are set at a falling edge; handshakes are predicted, then applied at the rising edge.
    task automatic step(output bit gc, output bit gd);
        #1;
        predict(gc, gd);
        chk("core_ready", {31'd0, CoreReady}, {31'd0, gc});
        chk("dbg_ready", {31'd0, DbgReady}, {31'd0, gd});
        chk("clear_busy", {31'd0, ClearBusy}, {31'd0, (clearLeft > 0) || clearVis});
        chk("last_grant", {31'd0, LastGrant}, {31'd0, lastG});
        @(posedge Clock);
        cycle++;
        modelEdge(gc, gd);
        @(negedge Clock);
    endtask

    task automatic runCycles(int n, int pCore, int pDbg, int pClear);
        bit gc;
        bit gd;
        for (int i = 0; i < n; i++) begin
            if (!CoreValid && $urandom_range(99) < pCore) begin
                CoreValid   = 1'b1;
                CoreAddress = 5'($urandom);
                CoreData    = $urandom;
            end
            if (!DbgValid && $urandom_range(99) < pDbg) begin
                DbgValid   = 1'b1;
                DbgAddress = 5'($urandom);
                DbgData    = $urandom;
            end
            ClearRequest = (pClear > 0) && ($urandom_range(999) < pClear);
            step(gc, gd);
            if (gc) CoreValid = 1'b0;
            if (gd) DbgValid = 1'b0;
            ClearRequest = 1'b0;
        end
    endtask

    // Monitor: every visible write must match the head of the queue in the exact cycle predicted.
    always @(negedge Clock) begin
        wr_t e;
        if (!Reset) begin
            if (expQ.size() > 0 && expQ[0].cyc == cycle) begin
                e = expQ.pop_front();
                chk("wr_enable", {31'd0, WriteControl}, 32'd1);
                chk("wr_addr", {27'd0, WriteRegAddress}, {27'd0, e.a});
                chk("wr_data", DataOfWrite, e.d);
            end else begin
                chk("wr_idle", {31'd0, WriteControl}, 32'd0);
            end
            if (WriteControl && WriteRegAddress != 5'd0) rf[WriteRegAddress] = DataOfWrite;
        end
    end

    initial begin
        bit gc;
        bit gd;
        checks = 0;
        failures = 0;
        cycle = 0;
        for (int i = 0; i < 32; i++) begin
            rf[i]    = 32'h0;
            expRf[i] = 32'h0;
        end
        Reset = 1'b1;
        CoreValid = 1'b0; CoreAddress = '0; CoreData = '0;
        DbgValid = 1'b0; DbgAddress = '0; DbgData = '0;
        ClearRequest = 1'b0;
        modelReset();

        repeat (2) @(posedge Clock);
        #1;
        chk("rst_wr_enable", {31'd0, WriteControl}, 32'd0);
        chk("rst_wr_addr", {27'd0, WriteRegAddress}, 32'd0);
        chk("rst_wr_data", DataOfWrite, 32'd0);
        chk("rst_last_grant", {31'd0, LastGrant}, 32'd1);
        chk("rst_clear_busy", {31'd0, ClearBusy}, 32'd1);
        @(negedge Clock);
        Reset = 1'b0;

        // Automatic clear after reset release, no requests.
        runCycles(34, 0, 0, 0);

        // Core-only write.
        CoreValid = 1'b1; CoreAddress = 5'd5; CoreData = 32'hDEADBEEF;
        step(gc, gd);
        if (gc) CoreValid = 1'b0;
        runCycles(2, 0, 0, 0);
        chk("rf_r5", rf[5], 32'hDEADBEEF);

        // Debug write to r0 is accepted but never enabled.
        DbgValid = 1'b1; DbgAddress = 5'd0; DbgData = 32'h12345678;
        step(gc, gd);
        if (gd) DbgValid = 1'b0;
        runCycles(2, 0, 0, 0);
        chk("rf_r0", rf[0], 32'h0);

        // Both valid for four cycles starting from LastGrant=1.
        runCycles(4, 100, 100, 0);
        runCycles(5, 0, 0, 0);

        // Clear request in the same cycle as a core request: request lands after the clear.
        CoreValid = 1'b1; CoreAddress = 5'd7; CoreData = 32'h55; ClearRequest = 1'b1;
        step(gc, gd);
        if (gc) CoreValid = 1'b0;
        ClearRequest = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(gc, gd);
            if (gc) CoreValid = 1'b0;
        end
        chk("rf_r7", rf[7], 32'h55);

        // Reset during the clear write to address 10, then restart from address 1.
        ClearRequest = 1'b1;
        step(gc, gd);
        ClearRequest = 1'b0;
        runCycles(10, 0, 0, 0);
        #2;
        Reset = 1'b1;
        #1;
        chk("midrst_wr_enable", {31'd0, WriteControl}, 32'd0);
        chk("midrst_wr_addr", {27'd0, WriteRegAddress}, 32'd0);
        chk("midrst_clear_busy", {31'd0, ClearBusy}, 32'd1);
        modelReset();
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        runCycles(34, 0, 0, 0);

        // Randomized traffic with occasional clears, then drain.
        runCycles(400, 40, 40, 10);
        runCycles(45, 0, 0, 0);

        chk("queue_empty", expQ.size(), 32'd0);
        for (int i = 0; i < 32; i++) begin
            chk("rf_final", rf[i], expRf[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
